// File: rtl/tx_initiated_point_test_rx.sv
// Partner-die responder for the TX-initiated D2C point test. It answers the remote initiator's
// sideband requests, sequences the local pattern comparators and reports per-lane results.
module tx_initiated_point_test_rx #(
  parameter int NUM_LANES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_lfsr_or_perlane,
  input  logic [3:0]           i_sideband_message,
  input  logic [15:0]          i_sideband_data,
  input  logic                 i_sideband_message_valid,
  input  logic [NUM_LANES-1:0] i_lane_error,
  input  logic                 i_val_error,
  input  logic                 i_busy_negedge_detected,
  input  logic                 i_valid_tx,
  output logic [3:0]           o_sideband_message,
  output logic                 o_valid_rx,
  output logic [15:0]          o_sideband_data,
  output logic                 o_data_valid,
  output logic [1:0]           o_mainband_comparator_cw,
  output logic                 o_val_comparator_en,
  output logic                 o_test_ack_rx
);

  // state      | meaning
  // IDLE       | test disabled, all outputs low
  // WAIT_START | waiting for start request
  // WAIT_CLEAR | start answered, waiting for LFSR clear request
  // COMPARE    | comparators running, waiting for result request
  // WAIT_END   | result answered, waiting for end request
  // END_RESP   | end response issued, waiting for its handshake
  // FINISHED   | ack to LTSM held until enable drops
  typedef enum logic [2:0] {
    IDLE, WAIT_START, WAIT_CLEAR, COMPARE, WAIT_END, END_RESP, FINISHED
  } state_t;

  localparam logic [3:0] REQ_START  = 4'b0001;
  localparam logic [3:0] REQ_CLEAR  = 4'b0011;
  localparam logic [3:0] REQ_RESULT = 4'b0101;
  localparam logic [3:0] REQ_END    = 4'b0111;
  localparam logic [3:0] RSP_START  = 4'b0010;
  localparam logic [3:0] RSP_CLEAR  = 4'b0100;
  localparam logic [3:0] RSP_RESULT = 4'b0110;
  localparam logic [3:0] RSP_END    = 4'b1000;

  state_t      state;
  logic        valtrain;
  logic        burst;
  logic        comp_mode;
  logic [15:0] result;
  logic        req_start, req_clear, req_result, req_end;
  logic        hs_done;

  // burst is kept with the config but the responder's own behaviour does not depend on it
  logic unused_cfg;
  assign unused_cfg = ^{i_sideband_data[15:6], i_sideband_data[3:1], burst};

  assign req_start  = i_sideband_message_valid && (i_sideband_message == REQ_START);
  assign req_clear  = i_sideband_message_valid && (i_sideband_message == REQ_CLEAR);
  assign req_result = i_sideband_message_valid && (i_sideband_message == REQ_RESULT);
  assign req_end    = i_sideband_message_valid && (i_sideband_message == REQ_END);
  assign hs_done    = i_busy_negedge_detected & ~i_valid_tx;

  always_comb begin
    result = '0;
    if (valtrain)
      result[0] = ~i_val_error;
    else if (comp_mode)
      result[0] = ~|i_lane_error;
    else
      result[NUM_LANES-1:0] = ~i_lane_error;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      state                    <= IDLE;
      valtrain                 <= 1'b0;
      burst                    <= 1'b0;
      comp_mode                <= 1'b0;
      o_sideband_message       <= '0;
      o_valid_rx               <= 1'b0;
      o_sideband_data          <= '0;
      o_data_valid             <= 1'b0;
      o_mainband_comparator_cw <= 2'b00;
      o_val_comparator_en      <= 1'b0;
      o_test_ack_rx            <= 1'b0;
    end else begin
      // handshake clear comes first so that a same-cycle issue below overrides it
      if (hs_done) begin
        o_valid_rx      <= 1'b0;
        o_data_valid    <= 1'b0;
        o_sideband_data <= '0;
      end
      case (state)
        IDLE: state <= WAIT_START;
        WAIT_START: begin
          if (req_start) begin
            valtrain           <= i_sideband_data[0];
            burst              <= i_sideband_data[4];
            comp_mode          <= i_sideband_data[5];
            o_sideband_message <= RSP_START;
            o_valid_rx         <= 1'b1;
            o_data_valid       <= 1'b0;
            o_sideband_data    <= '0;
            state              <= WAIT_CLEAR;
          end
        end
        WAIT_CLEAR: begin
          if (req_clear) begin
            o_sideband_message <= RSP_CLEAR;
            o_valid_rx         <= 1'b1;
            o_data_valid       <= 1'b0;
            o_sideband_data    <= '0;
            if (!valtrain) o_mainband_comparator_cw <= 2'b01;
            state              <= COMPARE;
          end
        end
        COMPARE: begin
          if (req_result) begin
            o_mainband_comparator_cw <= 2'b00;
            o_val_comparator_en      <= 1'b0;
            o_sideband_message       <= RSP_RESULT;
            o_valid_rx               <= 1'b1;
            o_data_valid             <= 1'b1;
            o_sideband_data          <= result;
            state                    <= WAIT_END;
          end else if (valtrain) begin
            o_val_comparator_en <= 1'b1;
          end else if (o_mainband_comparator_cw == 2'b01) begin
            o_mainband_comparator_cw <= i_lfsr_or_perlane ? 2'b11 : 2'b10;
          end
        end
        WAIT_END: begin
          if (req_end) begin
            o_sideband_message <= RSP_END;
            o_valid_rx         <= 1'b1;
            o_data_valid       <= 1'b0;
            o_sideband_data    <= '0;
            state              <= END_RESP;
          end
        end
        END_RESP: begin
          if (!o_valid_rx || hs_done) begin
            o_test_ack_rx <= 1'b1;
            state         <= FINISHED;
          end
        end
        FINISHED: o_test_ack_rx <= 1'b1;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_initiated_point_test_rx.sv
// Bench for tx_initiated_point_test_rx: directed and randomized request sequences checked
// against expectations derived from the message/result rules.
module tb_tx_initiated_point_test_rx;

  localparam int NL = 16;
  localparam logic [15:0] LANE_MASK = 16'((32'h1 << NL) - 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_en;
  logic          i_lfsr_or_perlane;
  logic [3:0]    i_sideband_message;
  logic [15:0]   i_sideband_data;
  logic          i_sideband_message_valid;
  logic [NL-1:0] i_lane_error;
  logic          i_val_error;
  logic          i_busy_negedge_detected;
  logic          i_valid_tx;
  logic [3:0]    o_sideband_message;
  logic          o_valid_rx;
  logic [15:0]   o_sideband_data;
  logic          o_data_valid;
  logic [1:0]    o_mainband_comparator_cw;
  logic          o_val_comparator_en;
  logic          o_test_ack_rx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tx_initiated_point_test_rx #(.NUM_LANES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_lfsr_or_perlane(i_lfsr_or_perlane),
    .i_sideband_message(i_sideband_message), .i_sideband_data(i_sideband_data),
    .i_sideband_message_valid(i_sideband_message_valid), .i_lane_error(i_lane_error),
    .i_val_error(i_val_error), .i_busy_negedge_detected(i_busy_negedge_detected),
    .i_valid_tx(i_valid_tx), .o_sideband_message(o_sideband_message), .o_valid_rx(o_valid_rx),
    .o_sideband_data(o_sideband_data), .o_data_valid(o_data_valid),
    .o_mainband_comparator_cw(o_mainband_comparator_cw),
    .o_val_comparator_en(o_val_comparator_en), .o_test_ack_rx(o_test_ack_rx)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: result word from the reporting rules
  function automatic logic [15:0] exp_result(input bit vt, input bit cm,
                                             input logic [15:0] le, input bit ve);
    if (vt) return {15'd0, ~ve};
    if (cm) return {15'd0, ((le & LANE_MASK) == 16'd0)};
    return ~le & LANE_MASK;
  endfunction

  // requests are strobed for one cycle; outputs are checked at the following negedge
  task automatic send(input logic [3:0] msg, input logic [15:0] data);
    i_sideband_message       = msg;
    i_sideband_data          = data;
    i_sideband_message_valid = 1'b1;
    @(negedge clk);
    i_sideband_message_valid = 1'b0;
    i_sideband_message       = 4'd0;
  endtask

  task automatic handshake(input bit tx_busy);
    i_busy_negedge_detected = 1'b1;
    i_valid_tx              = tx_busy;
    @(negedge clk);
    i_busy_negedge_detected = 1'b0;
    i_valid_tx              = 1'b0;
  endtask

  task automatic run_test(input logic [15:0] sdata, input bit perlane, input logic [15:0] le,
                          input bit ve, input bit stall, input bit stray);
    bit vt, cm;
    logic [3:0] stray_msg;
    vt = sdata[0];
    cm = sdata[5];
    i_lfsr_or_perlane = perlane;
    i_lane_error = '0;
    i_val_error  = 1'b0;
    i_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("ack_before_start", 16'(o_test_ack_rx), 16'd0);
    send(4'b0001, sdata);
    chk("start_rsp", 16'(o_sideband_message), 16'h2);
    chk("start_vrx", 16'(o_valid_rx), 16'd1);
    chk("start_dv", 16'(o_data_valid), 16'd0);
    if (stall) begin
      handshake(1'b1);
      chk("stall_vrx_held", 16'(o_valid_rx), 16'd1);
    end
    handshake(1'b0);
    chk("start_vrx_clr", 16'(o_valid_rx), 16'd0);
    if (stray) begin
      do stray_msg = 4'($urandom_range(0, 15)); while (stray_msg == 4'b0011);
      send(stray_msg, 16'($urandom));
      chk("stray_msg_kept", 16'(o_sideband_message), 16'h2);
      chk("stray_no_vrx", 16'(o_valid_rx), 16'd0);
    end
    send(4'b0011, 16'($urandom));
    chk("clear_rsp", 16'(o_sideband_message), 16'h4);
    chk("clear_cw", 16'(o_mainband_comparator_cw), vt ? 16'd0 : 16'd1);
    chk("clear_val_en", 16'(o_val_comparator_en), 16'd0);
    handshake(1'b0);
    chk("cmp_cw", 16'(o_mainband_comparator_cw), vt ? 16'd0 : (perlane ? 16'd3 : 16'd2));
    chk("cmp_val_en", 16'(o_val_comparator_en), 16'(vt));
    i_lane_error = le[NL-1:0];
    i_val_error  = ve;
    send(4'b0101, 16'd0);
    i_lane_error = '0;
    i_val_error  = 1'b0;
    chk("result_rsp", 16'(o_sideband_message), 16'h6);
    chk("result_dv", 16'(o_data_valid), 16'd1);
    chk("result_data", o_sideband_data, exp_result(vt, cm, le, ve));
    chk("result_cw_off", 16'(o_mainband_comparator_cw), 16'd0);
    chk("result_val_off", 16'(o_val_comparator_en), 16'd0);
    handshake(1'b0);
    chk("result_dv_clr", 16'(o_data_valid), 16'd0);
    chk("result_data_clr", o_sideband_data, 16'd0);
    send(4'b0111, 16'd0);
    chk("end_rsp", 16'(o_sideband_message), 16'h8);
    chk("end_vrx", 16'(o_valid_rx), 16'd1);
    chk("end_no_ack_yet", 16'(o_test_ack_rx), 16'd0);
    handshake(1'b0);
    chk("end_vrx_clr", 16'(o_valid_rx), 16'd0);
    chk("ack_set", 16'(o_test_ack_rx), 16'd1);
    send(4'b0001, 16'd0);
    chk("ack_held", 16'(o_test_ack_rx), 16'd1);
    chk("finished_ignores_req", 16'(o_valid_rx), 16'd0);
    i_en = 1'b0;
    @(negedge clk);
    chk("disable_ack", 16'(o_test_ack_rx), 16'd0);
    chk("disable_msg", 16'(o_sideband_message), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_en = 1'b0;
    i_lfsr_or_perlane = 1'b0;
    i_sideband_message = '0;
    i_sideband_data = '0;
    i_sideband_message_valid = 1'b0;
    i_lane_error = '0;
    i_val_error = 1'b0;
    i_busy_negedge_detected = 1'b0;
    i_valid_tx = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_msg", 16'(o_sideband_message), 16'd0);
    chk("rst_vrx", 16'(o_valid_rx), 16'd0);
    chk("rst_cw", 16'(o_mainband_comparator_cw), 16'd0);
    chk("rst_ack", 16'(o_test_ack_rx), 16'd0);
    i_en = 1'b1;
    @(negedge clk);
    chk("rst_beats_en", 16'(o_valid_rx), 16'd0);
    rst_n = 1'b1;
    i_en = 1'b0;
    @(negedge clk);

    // mainband LFSR, lanes 3 and 9 failing, with TX stall and stray request
    run_test(16'h0000, 1'b0, 16'h0208, 1'b0, 1'b1, 1'b1);
    chk("lfsr_result_const", exp_result(1'b0, 1'b0, 16'h0208, 1'b0), 16'hFDF7);
    // valid-train
    run_test(16'h0031, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    // aggregate mode, per-lane compare, one failing lane
    run_test(16'h0020, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0);

    // abort during COMPARE with a response still pending
    i_lfsr_or_perlane = 1'b0;
    i_en = 1'b1;
    repeat (2) @(negedge clk);
    send(4'b0001, 16'h0000);
    send(4'b0011, 16'h0000);
    chk("overwrite_rsp", 16'(o_sideband_message), 16'h4);
    chk("overwrite_vrx", 16'(o_valid_rx), 16'd1);
    @(negedge clk);
    chk("abort_pre_cw", 16'(o_mainband_comparator_cw), 16'd2);
    i_en = 1'b0;
    @(negedge clk);
    chk("abort_cw", 16'(o_mainband_comparator_cw), 16'd0);
    chk("abort_vrx", 16'(o_valid_rx), 16'd0);
    chk("abort_msg", 16'(o_sideband_message), 16'd0);
    chk("abort_ack", 16'(o_test_ack_rx), 16'd0);
    i_en = 1'b1;
    repeat (2) @(negedge clk);
    send(4'b0001, 16'h0000);
    chk("restart_rsp", 16'(o_sideband_message), 16'h2);
    chk("restart_vrx", 16'(o_valid_rx), 16'd1);
    i_en = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      logic [15:0] sd;
      sd = 16'($urandom);
      run_test(sd, 1'($urandom), 16'($urandom) & 16'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
